// File: rtl/out_chn_fsm.sv
// rtl/out_chn_fsm.sv - output channel controller: drains a destination FIFO, sends header+payload over valid/ready
// Header length field sets the payload byte count; zero-length headers are dropped and flagged.
module out_chn_fsm #(
  parameter int data_size       = 8,
  parameter int pkt_length_bits = 5,
  parameter int pkt_addr_bits   = data_size - pkt_length_bits,
  parameter int pkt_cnt_bits    = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_ch_en,
  input  logic                     i_clr_errors,
  input  logic                     i_fifo_empty,
  output logic                     o_fifo_rd_en,
  input  logic [data_size-1:0]     i_fifo_data,
  output logic [data_size-1:0]     o_data_out,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_busy,
  output logic                     o_error,
  output logic [pkt_addr_bits-1:0] o_pkt_addr,
  output logic [pkt_cnt_bits-1:0]  o_pkt_cnt
);

  typedef enum logic [2:0] {
    IDLE, RD_HDR, LD_HDR, SEND_HDR, RD_DATA, LD_DATA, SEND_DATA
  } state_t;

  localparam logic [pkt_length_bits-1:0] LEN_ONE = 1;
  localparam logic [pkt_cnt_bits-1:0]    CNT_ONE = 1;

  state_t                     r_state;
  state_t                     w_next;
  logic [data_size-1:0]       r_data_out;
  logic                       r_valid;
  logic                       r_error;
  logic [pkt_addr_bits-1:0]   r_pkt_addr;
  logic [pkt_cnt_bits-1:0]    r_pkt_cnt;
  logic [pkt_length_bits-1:0] r_remaining;

  logic [pkt_length_bits-1:0] w_len;
  logic                       w_xfer;
  logic [pkt_length_bits-1:0] w_rem_next;
  logic                       w_last;
  logic                       w_err_set;

  assign w_len      = i_fifo_data[pkt_length_bits-1:0];
  assign w_xfer     = r_valid && i_ready;
  assign w_rem_next = (r_state == SEND_DATA && w_xfer) ? r_remaining - LEN_ONE : r_remaining;
  assign w_last     = (r_state == SEND_DATA) && w_xfer && (w_rem_next == '0);
  assign w_err_set  = (r_state == LD_HDR) && (w_len == '0);

  assign o_fifo_rd_en = (r_state == RD_HDR) || (r_state == RD_DATA);
  assign o_busy       = (r_state != IDLE);
  assign o_data_out   = r_data_out;
  assign o_valid      = r_valid;
  assign o_error      = r_error;
  assign o_pkt_addr   = r_pkt_addr;
  assign o_pkt_cnt    = r_pkt_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (i_ch_en && !i_fifo_empty) w_next = RD_HDR;
      RD_HDR:   w_next = LD_HDR;
      LD_HDR:   w_next = (w_len != '0) ? SEND_HDR : IDLE;
      // A mid-packet empty FIFO just parks here with o_valid low until data arrives.
      SEND_HDR, SEND_DATA: begin
        if (w_last)                               w_next = IDLE;
        else if ((w_xfer || !r_valid) && !i_fifo_empty) w_next = RD_DATA;
      end
      RD_DATA:  w_next = LD_DATA;
      LD_DATA:  w_next = SEND_DATA;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_data_out  <= '0;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
      r_pkt_addr  <= '0;
      r_pkt_cnt   <= '0;
      r_remaining <= '0;
    end else begin
      if (r_state == LD_HDR && w_len != '0) begin
        r_data_out  <= i_fifo_data;
        r_valid     <= 1'b1;
        r_pkt_addr  <= i_fifo_data[data_size-1:pkt_length_bits];
        r_remaining <= w_len;
      end
      if (r_state == LD_DATA) begin
        r_data_out <= i_fifo_data;
        r_valid    <= 1'b1;
      end
      if (w_xfer) begin
        r_valid     <= 1'b0;
        r_remaining <= w_rem_next;
      end
      if (w_last) r_pkt_cnt <= r_pkt_cnt + CNT_ONE;
      if (w_err_set)         r_error <= 1'b1;
      else if (i_clr_errors) r_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_out_chn_fsm.sv
// tb/tb_out_chn_fsm.sv - directed self-checking bench for out_chn_fsm with a small FIFO model
module tb_out_chn_fsm;

  logic        clk = 1'b0;
  logic        rstn, ch_en, clr_errors, ready, fifo_empty, fifo_rd_en;
  logic [7:0]  fifo_data, data_out;
  logic        valid, busy, error;
  logic [2:0]  pkt_addr;
  logic [15:0] pkt_cnt;

  always #5 clk = ~clk;

  out_chn_fsm dut (
    .i_clk(clk), .i_rstn(rstn), .i_ch_en(ch_en), .i_clr_errors(clr_errors),
    .i_fifo_empty(fifo_empty), .o_fifo_rd_en(fifo_rd_en), .i_fifo_data(fifo_data),
    .o_data_out(data_out), .o_valid(valid), .i_ready(ready), .o_busy(busy),
    .o_error(error), .o_pkt_addr(pkt_addr), .o_pkt_cnt(pkt_cnt)
  );

  // FIFO model: read data is registered, valid the cycle after the strobe
  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       fifo_clr = 1'b0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_clr) rd_ptr <= 0;
    else if (fifo_rd_en && wr_ptr != rd_ptr) begin
      fifo_data <= mem[rd_ptr[5:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  logic [7:0] out_b [0:63];
  int         out_n = 0;
  int         rd_cnt = 0;
  int         valid_cyc = 0;

  always @(negedge clk) begin
    if (valid && ready) begin
      out_b[out_n[5:0]] <= data_out;
      out_n <= out_n + 1;
    end
    if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (valid) valid_cyc <= valid_cyc + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; ch_en = 1'b1; clr_errors = 1'b0; ready = 1'b1;
    fifo_clr = 1'b1;
    tick();
    tick();
    wr_ptr = 0;
    fifo_clr = 1'b0;
    rstn = 1'b1;
    tick();
  endtask

  task automatic wait_done(input string tag, input int max);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (!busy && wr_ptr == rd_ptr) begin ok = 1; break; end
    end
    if (!ok) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_byte(input string tag, input logic [7:0] b, input int max);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      if (valid && data_out == b) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk({tag, "_timeout"}, 0, 1);
  endtask

  int ob, rb, vb;

  initial begin
    rstn = 1'b0; ch_en = 1'b0; clr_errors = 1'b0; ready = 1'b0;
    #2;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_data", data_out, 0);
    chk("rst_error", error, 0);
    chk("rst_addr", pkt_addr, 0);
    chk("rst_cnt", pkt_cnt, 0);

    // basic packet
    do_reset();
    ob = out_n; rb = rd_cnt; vb = valid_cyc;
    push(8'h63); push(8'hA1); push(8'hB2); push(8'hC3);
    wait_done("t1", 40);
    chk("t1_nout", out_n - ob, 4);
    chk("t1_b0", out_b[ob],   8'h63);
    chk("t1_b1", out_b[ob+1], 8'hA1);
    chk("t1_b2", out_b[ob+2], 8'hB2);
    chk("t1_b3", out_b[ob+3], 8'hC3);
    chk("t1_vcyc", valid_cyc - vb, 4);
    chk("t1_rd", rd_cnt - rb, 4);
    chk("t1_addr", pkt_addr, 3);
    chk("t1_cnt", pkt_cnt, 1);
    chk("t1_busy", busy, 0);

    // backpressure on 0xB2
    ob = out_n; rb = rd_cnt; vb = valid_cyc;
    push(8'h63); push(8'hA1); push(8'hB2); push(8'hC3);
    wait_byte("t2", 8'hB2, 40);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", valid, 1);
      chk("t2_hold_data", data_out, 8'hB2);
    end
    chk("t2_rd_stall", rd_cnt - rb, 3);
    ready = 1'b1;
    wait_done("t2", 40);
    chk("t2_nout", out_n - ob, 4);
    chk("t2_b2", out_b[ob+2], 8'hB2);
    chk("t2_b3", out_b[ob+3], 8'hC3);
    chk("t2_vcyc", valid_cyc - vb, 9);
    chk("t2_rd", rd_cnt - rb, 4);
    chk("t2_cnt", pkt_cnt, 2);

    // zero-length header then a legal packet
    do_reset();
    ob = out_n;
    push(8'h40); push(8'h21); push(8'h5A);
    wait_done("t3", 40);
    chk("t3_nout", out_n - ob, 2);
    chk("t3_b0", out_b[ob],   8'h21);
    chk("t3_b1", out_b[ob+1], 8'h5A);
    chk("t3_error", error, 1);
    chk("t3_addr", pkt_addr, 1);
    chk("t3_cnt", pkt_cnt, 1);

    // error clear, and set winning over clear
    clr_errors = 1'b1;
    tick();
    clr_errors = 1'b0;
    chk("t4_clr", error, 0);
    clr_errors = 1'b1;
    push(8'h00);
    wait_done("t4", 20);
    chk("t4_set_wins", error, 1);
    clr_errors = 1'b0;
    chk("t4_cnt", pkt_cnt, 1);

    // FIFO runs dry after the header
    do_reset();
    ob = out_n;
    push(8'h02);
    wait_byte("t5", 8'h02, 20);
    tick();
    rb = rd_cnt;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_wait_valid", valid, 0);
      chk("t5_wait_rd", fifo_rd_en, 0);
    end
    chk("t5_wait_busy", busy, 1);
    chk("t5_rd_idle", rd_cnt - rb, 0);
    push(8'hAA); push(8'hBB);
    wait_done("t5", 40);
    chk("t5_nout", out_n - ob, 3);
    chk("t5_b1", out_b[ob+1], 8'hAA);
    chk("t5_b2", out_b[ob+2], 8'hBB);
    chk("t5_error", error, 0);
    chk("t5_cnt", pkt_cnt, 1);

    // asynchronous reset mid-packet, FIFO left holding the tail
    do_reset();
    push(8'h85); push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    wait_byte("t6", 8'h22, 40);
    rstn = 1'b0;
    #1;
    chk("t6_valid", valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rd_en", fifo_rd_en, 0);
    ch_en = 1'b0;
    tick();
    rstn = 1'b1;
    rb = rd_cnt;
    for (int i = 0; i < 8; i++) tick();
    chk("t6_no_rd", rd_cnt - rb, 0);
    chk("t6_idle", busy, 0);
    chk("t6_fifo_left", wr_ptr - rd_ptr, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
